// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: the queued entry layout and the decode NOP.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0); decode substitutes it when the queue is empty.
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Mod-DEPTH queue pointer with synchronous reset, clear and increment.
module fetch_queue_ptr #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Wrap by explicit compare so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// DEPTH-entry FIFO of fetched instructions tagged with their PC, between instruction
// memory and decode; valid/ready on both sides plus a flush for redirects.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [XLEN-1:0]  enq_instr,
  input  logic [XLEN-1:0]  enq_pc,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [XLEN-1:0]  deq_instr,
  output logic [XLEN-1:0]  deq_pc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             enq_fire;
  logic             deq_fire;

  // Ready depends on occupancy only, never on deq_ready.
  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign count     = count_q;

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (enq_fire),
    .ptr   (wr_ptr)
  );

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (deq_fire),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (enq_fire && !flush && !reset) begin
      mem[wr_ptr].instr <= enq_instr;
      mem[wr_ptr].pc    <= enq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
    end else begin
      unique case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    deq_instr = '0;
    deq_pc    = '0;
    if (deq_valid) begin
      deq_instr = mem[rd_ptr].instr;
      deq_pc    = mem[rd_ptr].pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a DEPTH=4 instance for most steps and a DEPTH=3 one for wrap.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_flush, a_enq_valid, a_enq_ready, a_deq_valid, a_deq_ready;
  logic [31:0] a_enq_instr, a_enq_pc, a_deq_instr, a_deq_pc;
  logic [2:0]  a_count;

  logic        b_flush, b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready;
  logic [31:0] b_enq_instr, b_enq_pc, b_deq_instr, b_deq_pc;
  logic [1:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.XLEN(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(a_flush),
    .enq_valid(a_enq_valid), .enq_ready(a_enq_ready),
    .enq_instr(a_enq_instr), .enq_pc(a_enq_pc),
    .deq_valid(a_deq_valid), .deq_ready(a_deq_ready),
    .deq_instr(a_deq_instr), .deq_pc(a_deq_pc), .count(a_count)
  );

  instr_fetch_queue #(.XLEN(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .enq_valid(b_enq_valid), .enq_ready(b_enq_ready),
    .enq_instr(b_enq_instr), .enq_pc(b_enq_pc),
    .deq_valid(b_deq_valid), .deq_ready(b_deq_ready),
    .deq_instr(b_deq_instr), .deq_pc(b_deq_pc), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy must never exceed depth.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("count_bound4", 32'(a_count <= 3'd4), 32'd1);
      chk("count_bound3", 32'(b_count <= 2'd3), 32'd1);
    end
  end

  task automatic enq4(input logic [31:0] instr, input logic [31:0] pc);
    a_enq_valid = 1'b1; a_enq_instr = instr; a_enq_pc = pc;
    step();
    a_enq_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 1'b0; a_enq_valid = 1'b0; a_deq_ready = 1'b0; a_enq_instr = '0; a_enq_pc = '0;
    b_flush = 1'b0; b_enq_valid = 1'b0; b_deq_ready = 1'b0; b_enq_instr = '0; b_enq_pc = '0;
    step(); step();
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_deq_valid", 32'(a_deq_valid), 32'd0);
      chk("rst_deq_instr", a_deq_instr, 32'd0);
      chk("rst_deq_pc", a_deq_pc, 32'd0);
      chk("rst_enq_ready", 32'(a_enq_ready), 32'd1);
      step();
    end

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      enq4(32'hA0 + 32'(i), 32'(4 * i));
      chk("fill_count", 32'(a_count), 32'(i + 1));
    end
    chk("full_enq_ready", 32'(a_enq_ready), 32'd0);
    chk("full_head", a_deq_instr, 32'hA0);
    a_deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(a_deq_valid), 32'd1);
      chk("drain_instr", a_deq_instr, 32'hA0 + 32'(i));
      chk("drain_pc", a_deq_pc, 32'(4 * i));
      step();
    end
    a_deq_ready = 1'b0;
    chk("drained_valid", 32'(a_deq_valid), 32'd0);
    chk("drained_instr", a_deq_instr, 32'd0);
    chk("drained_count", 32'(a_count), 32'd0);

    // Full with simultaneous enq+deq: enq refused, head pops
    for (int i = 0; i < 4; i++) enq4(32'hD0 + 32'(i), 32'h40 + 32'(4 * i));
    a_enq_valid = 1'b1; a_enq_instr = 32'hBB; a_enq_pc = 32'hBB0; a_deq_ready = 1'b1;
    chk("fullsim_enq_ready", 32'(a_enq_ready), 32'd0);
    step();
    a_enq_valid = 1'b0;
    chk("fullsim_count", 32'(a_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("fullsim_instr", a_deq_instr, 32'hD0 + 32'(i));
      step();
    end
    a_deq_ready = 1'b0;
    chk("fullsim_empty", 32'(a_deq_valid), 32'd0);

    // Flush with same-cycle enqueue
    enq4(32'hE0, 32'h60);
    enq4(32'hE1, 32'h64);
    chk("preflush_count", 32'(a_count), 32'd2);
    a_flush = 1'b1; a_enq_valid = 1'b1; a_enq_instr = 32'hCC; a_enq_pc = 32'hCC0;
    step();
    a_flush = 1'b0; a_enq_valid = 1'b0;
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_deq_valid", 32'(a_deq_valid), 32'd0);
    chk("flush_enq_ready", 32'(a_enq_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_cc", a_deq_instr, 32'd0);
      step();
    end

    // Simultaneous enq+deq when empty: only enq fires
    a_enq_valid = 1'b1; a_enq_instr = 32'h77; a_enq_pc = 32'h70; a_deq_ready = 1'b1;
    chk("emptysim_valid", 32'(a_deq_valid), 32'd0);
    step();
    a_enq_valid = 1'b0; a_deq_ready = 1'b0;
    chk("emptysim_count", 32'(a_count), 32'd1);
    chk("emptysim_instr", a_deq_instr, 32'h77);
    reset = 1'b1; step(); reset = 1'b0;

    // Stall hold: head steady while queue saturates
    enq4(32'hF0, 32'h80);
    chk("stall_start", 32'(a_count), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      a_enq_valid = 1'b1; a_enq_instr = 32'hF0 + 32'(i); a_enq_pc = 32'h80 + 32'(4 * i);
      step();
      chk("stall_instr", a_deq_instr, 32'hF0);
      chk("stall_pc", a_deq_pc, 32'h80);
      chk("stall_count", 32'((i + 1 > 4) ? 4 : i + 1), 32'(a_count));
    end
    a_enq_valid = 1'b0;
    chk("stall_enq_ready", 32'(a_enq_ready), 32'd0);
    a_deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_drain", a_deq_instr, 32'hF0 + 32'(i));
      step();
    end
    a_deq_ready = 1'b0;
    chk("stall_empty", 32'(a_deq_valid), 32'd0);

    // Reset mid-operation
    enq4(32'h11, 32'h0);
    enq4(32'h22, 32'h4);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_count", 32'(a_count), 32'd0);
    chk("midrst_valid", 32'(a_deq_valid), 32'd0);

    // Wrap-around streaming on DEPTH=3
    b_deq_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      b_enq_valid = (i < 10);
      b_enq_instr = 32'h100 + 32'(i);
      b_enq_pc    = 32'(4 * i);
      if (i == 0) chk("wrap_first_valid", 32'(b_deq_valid), 32'd0);
      else begin
        chk("wrap_valid", 32'(b_deq_valid), 32'd1);
        chk("wrap_instr", b_deq_instr, 32'h100 + 32'(i - 1));
        chk("wrap_pc", b_deq_pc, 32'(4 * (i - 1)));
      end
      step();
      chk("wrap_count", 32'(b_count), (i < 10) ? 32'd1 : 32'd0);
    end
    b_enq_valid = 1'b0; b_deq_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry FIFO of fetched instructions, each tagged with its PC.
- Sits between instruction memory and decode.
- Decouples fetch from decode/execute with valid/ready handshakes on both sides, so fetch can run ahead during multicycle execution.
- Adds a flush for redirects (branch/jump/trap); the old register had no equivalent.

Parameters:
- XLEN, 32, instruction and PC width in bits.
- DEPTH, 4, number of queue entries; legal range 2..16, need not be a power of two.
- CNT_W, $clog2(DEPTH+1), occupancy count width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears queue.
- flush  input  1  synchronous; discards all entries (redirect).
- enq_valid  input  1  fetch presents an instruction.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_instr  input  XLEN  fetched instruction word.
- enq_pc  input  XLEN  PC of enq_instr.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  decode consumes head this cycle.
- deq_instr  output  XLEN  head instruction.
- deq_pc  output  XLEN  head PC.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset: count=0, rd/wr pointers=0, deq_valid=0, deq_instr=0, deq_pc=0, enq_ready=1. Storage contents are don't-care.
- Priority each cycle: reset > flush > normal enq/deq.
- enq_ready = (count != DEPTH). It is combinational from state only, with no dependence on deq_ready, so there is no ready-to-ready path.
- Enqueue fires when enq_valid && enq_ready. The entry is written at wr_ptr, and wr_ptr advances.
- Dequeue fires when deq_valid && deq_ready. rd_ptr advances.
- deq_valid = (count != 0).
- deq_instr/deq_pc are driven from the head entry when deq_valid=1, and forced to 0 when deq_valid=0.
- Latency: an entry written into an empty queue becomes visible at deq_* on the next cycle. There is no same-cycle bypass.
- Pointer wrap: a pointer at DEPTH-1 goes to 0, with an explicit compare. Do not rely on power-of-two overflow.
- Count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Simultaneous enq+deq when full: enq is refused (enq_ready=0), deq proceeds, count becomes DEPTH-1.
- Simultaneous enq+deq when empty: deq does not fire (deq_valid=0), enq proceeds, count becomes 1.
- enq_valid while enq_ready=0: ignored, no state change. Fetch must hold the data.
- deq_ready while deq_valid=0: ignored.
- Head stability: while deq_valid=1 and deq_ready=0, deq_instr/deq_pc stay constant, matching the old register's hold semantics.
- Flush: next cycle count=0, pointers=0, deq_valid=0. A same-cycle enqueue is dropped, and a same-cycle dequeue is still considered consumed by decode. enq_ready=1 the cycle after flush.
- Reset mid-operation: identical effect to flush. There is no partial drain.
- No overflow or underflow is possible by construction. The bench asserts count <= DEPTH at all times.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_entry_t, a packed struct {instr[XLEN-1:0], pc[XLEN-1:0]};
  - localparam NOP_INSTR = 32'h0000_0013, for decode use; the queue itself outputs 0 when empty.
- One sub-module, fetch_queue_ptr: a mod-DEPTH pointer with inputs clk, reset, clr, inc and output ptr. It is instantiated twice (rd and wr).
- Storage is an array of fetch_entry_t inside instr_fetch_queue.

Test Plan:
- Reset then idle: after reset, count=0, deq_valid=0, deq_instr=0, enq_ready=1, held over 5 cycles.
- Fill then drain (DEPTH=4): enqueue pc 0x00,0x04,0x08,0x0C with instr 0xA0..0xA3 and deq_ready=0.
  - Required: enq_ready=0 at count=4.
  - Then deq_ready=1: instrs emerge 0xA0..0xA3 in order on consecutive cycles, and deq_valid=0 after the 4th.
- Wrap-around (DEPTH=3): continuous enq+deq streaming of 10 instrs 0x100+i. Required: all 10 emerge in order, and count stays at 1 after the first fill.
- Full with simultaneous enq+deq: at count=4, assert enq_valid (instr 0xBB) and deq_ready. Required: 0xBB is not accepted, head pops, count=3.
- Flush with same-cycle enq: count=2, flush=1 and enq_valid=1 (instr 0xCC). Required: next cycle count=0, deq_valid=0, and 0xCC never appears.
- Stall hold: count=1, deq_ready=0 for 6 cycles while enqueuing. Required: deq_instr/deq_pc stay unchanged, and count saturates at DEPTH with enq_ready=0.
